// File: rtl/ifid_stage_reg.sv
// Fetch-side pipeline stage: owns the PC and the IF/ID register and applies
// the hazard unit's flush/stall. Also keeps saturating stall/flush counters.
module ifid_stage_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] pc_target,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_pc_plus_4,
    output logic                  id_valid,
    output logic                  idex_bubble,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_redirect;
    logic                  stall_sat;
    logic                  flush_sat;

    // Redirect targets are forced word-aligned before they reach the PC.
    assign pc_redirect = {pc_target[DATA_WIDTH-1:2], 2'b00};
    assign stall_sat   = (stall_cnt == {CNT_WIDTH{1'b1}});
    assign flush_sat   = (flush_cnt == {CNT_WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q      <= RESET_PC;
            id_instr  <= NOP_INSTR;
            id_pc     <= '0;
            id_valid  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            pc_q     <= pc_redirect;
            id_instr <= NOP_INSTR;
            id_pc    <= pc_q;
            id_valid <= 1'b0;
            if (!flush_sat) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end else if (stall) begin
            if (!stall_sat) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
        end else begin
            pc_q     <= pc_q + DATA_WIDTH'(4);
            id_instr <= imem_rdata;
            id_pc    <= pc_q;
            id_valid <= 1'b1;
        end
    end

    // The bubble request is deliberately not gated by reset; consumers do that.
    assign idex_bubble  = stall | flush;
    assign imem_addr    = pc_q;
    assign id_pc_plus_4 = id_pc + DATA_WIDTH'(4);

endmodule

// File: tb/tb_ifid_stage_reg.sv
// Directed bench for ifid_stage_reg: a default instance for the main flow and
// a CNT_WIDTH=2 instance for counter saturation and PC wrap.
module tb_ifid_stage_reg;

    logic        clk = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic        rstn, stall, flush;
    logic [31:0] pc_target, imem_rdata;
    logic [31:0] imem_addr, id_instr, id_pc, id_pc_plus_4;
    logic        id_valid, idex_bubble;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_rstn, s_stall, s_flush;
    logic [31:0] s_pc_target, s_imem_rdata;
    logic [31:0] s_imem_addr, s_id_instr, s_id_pc, s_id_pc_plus_4;
    logic        s_id_valid, s_idex_bubble;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    ifid_stage_reg dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .pc_target(pc_target), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus_4(id_pc_plus_4), .id_valid(id_valid),
        .idex_bubble(idex_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ifid_stage_reg #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rstn(s_rstn), .stall(s_stall), .flush(s_flush),
        .pc_target(s_pc_target), .imem_rdata(s_imem_rdata),
        .imem_addr(s_imem_addr), .id_instr(s_id_instr), .id_pc(s_id_pc),
        .id_pc_plus_4(s_id_pc_plus_4), .id_valid(s_id_valid),
        .idex_bubble(s_idex_bubble), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic f,
                                 input logic [31:0] tgt, input logic [31:0] rd);
        rstn       = r;
        stall      = s;
        flush      = f;
        pc_target  = tgt;
        imem_rdata = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] ipc, input logic vld);
        checkOutput({tag, ".pc"}, imem_addr, pc);
        checkOutput({tag, ".instr"}, id_instr, ins);
        checkOutput({tag, ".id_pc"}, id_pc, ipc);
        checkOutput({tag, ".pc4"}, id_pc_plus_4, ipc + 32'd4);
        checkOutput({tag, ".valid"}, {31'd0, id_valid}, {31'd0, vld});
    endtask

    initial begin
        s_rstn = 1'b0; s_stall = 1'b0; s_flush = 1'b0;
        s_pc_target = '0; s_imem_rdata = '0;

        // Reset
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkState("reset", 32'h0, 32'h13, 32'h0, 1'b0);
        checkOutput("reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        checkOutput("reset.flush_cnt", {16'd0, flush_cnt}, 32'd0);
        checkOutput("reset.bubble", {31'd0, idex_bubble}, 32'd0);

        // Three advances
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'hAAAA_0001);
        tick();
        checkState("adv0", 32'h4, 32'hAAAA_0001, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'hBBBB_0002);
        tick();
        checkState("adv1", 32'h8, 32'hBBBB_0002, 32'h4, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'hCCCC_0003);
        tick();
        checkState("adv2", 32'hC, 32'hCCCC_0003, 32'h8, 1'b1);

        // Three stall cycles
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'hDDDD_0004);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall.bubble", {31'd0, idex_bubble}, 32'd1);
            tick();
            checkState("stall", 32'hC, 32'hCCCC_0003, 32'h8, 1'b1);
        end
        checkOutput("stall.cnt", {16'd0, stall_cnt}, 32'd3);

        // Resume at held PC
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'hDDDD_0004);
        checkOutput("resume.bubble", {31'd0, idex_bubble}, 32'd0);
        tick();
        checkState("resume", 32'h10, 32'hDDDD_0004, 32'hC, 1'b1);

        // Flush with misaligned target
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'hEEEE_0005);
        checkOutput("flush.bubble", {31'd0, idex_bubble}, 32'd1);
        tick();
        checkState("flush", 32'h100, 32'h13, 32'h10, 1'b0);
        checkOutput("flush.cnt", {16'd0, flush_cnt}, 32'd1);

        // Stall right after flush holds the bubble
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'hEEEE_0005);
        tick();
        checkState("stall_after_flush", 32'h100, 32'h13, 32'h10, 1'b0);
        checkOutput("stall_after_flush.cnt", {16'd0, stall_cnt}, 32'd4);

        // Flush and stall together: flush wins
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'hEEEE_0005);
        checkOutput("both.bubble", {31'd0, idex_bubble}, 32'd1);
        tick();
        checkState("both", 32'h200, 32'h13, 32'h100, 1'b0);
        checkOutput("both.flush_cnt", {16'd0, flush_cnt}, 32'd2);
        checkOutput("both.stall_cnt", {16'd0, stall_cnt}, 32'd4);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_0006);
        tick();
        checkState("adv3", 32'h204, 32'hFFFF_0006, 32'h200, 1'b1);

        // Reset during a stall burst
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("burst.cnt", {16'd0, stall_cnt}, 32'd5);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        checkOutput("rst_burst.bubble", {31'd0, idex_bubble}, 32'd1);
        tick();
        checkState("rst_burst", 32'h0, 32'h13, 32'h0, 1'b0);
        checkOutput("rst_burst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        checkOutput("rst_burst.flush_cnt", {16'd0, flush_cnt}, 32'd0);

        // Narrow-counter instance: saturation and PC wrap
        s_rstn = 1'b0;
        tick();
        s_rstn = 1'b1; s_stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checkOutput($sformatf("sat.stall_cnt%0d", i), {30'd0, s_stall_cnt},
                        (i > 3) ? 32'd3 : 32'(i));
        end
        checkOutput("sat.pc_held", s_imem_addr, 32'h0);
        s_stall = 1'b0; s_flush = 1'b1; s_pc_target = 32'hFFFF_FFFF;
        tick();
        checkOutput("sat.flush_pc", s_imem_addr, 32'hFFFF_FFFC);
        checkOutput("sat.flush_cnt1", {30'd0, s_flush_cnt}, 32'd1);
        s_flush = 1'b0; s_imem_rdata = 32'h1234_5678;
        tick();
        checkOutput("wrap.pc", s_imem_addr, 32'h0);
        checkOutput("wrap.id_pc", s_id_pc, 32'hFFFF_FFFC);
        checkOutput("wrap.pc4", s_id_pc_plus_4, 32'h0);
        checkOutput("wrap.instr", s_id_instr, 32'h1234_5678);
        s_flush = 1'b1; s_pc_target = 32'h40;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("sat.flush_cnt", {30'd0, s_flush_cnt}, 32'd3);
        checkOutput("sat.stall_kept", {30'd0, s_stall_cnt}, 32'd3);
        s_flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
